// File: rtl/wav_pkg.sv
// Shared types and constants for the WAV PCM streamer: FSM states, header
// layout and the ASCII chunk tags checked during header validation.
package wav_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HDR   = 4'd1,
        ST_CHECK = 4'd2,
        ST_FETCH = 4'd3,
        ST_WAIT  = 4'd4,
        ST_WRITE = 4'd5,
        ST_END   = 4'd6,
        ST_DRAIN = 4'd7,
        ST_DONE  = 4'd8,
        ST_ERROR = 4'd9
    } wav_state_e;

    localparam int HDR_BYTES = 44;
    localparam int DATA_OFS  = 44;

    // Chunk tags as they appear in memory, first character in the MSB.
    localparam logic [31:0] ASCII_RIFF = 32'h52494646;
    localparam logic [31:0] ASCII_WAVE = 32'h57415645;
    localparam logic [31:0] ASCII_DATA = 32'h64617461;

    // Byte offsets of the header fields the streamer inspects.
    localparam int OFS_RIFF      = 0;
    localparam int OFS_WAVE      = 8;
    localparam int OFS_FMT       = 20;
    localparam int OFS_CHANNELS  = 22;
    localparam int OFS_BPS       = 34;
    localparam int OFS_DATA_ID   = 36;
    localparam int OFS_DATA_SIZE = 40;

    // Bytes per PCM frame for the four supported channel/width combinations.
    function automatic logic [2:0] frame_bytes(input logic stereo, input logic bits16);
        logic [2:0] fb;
        case ({stereo, bits16})
            2'b00:   fb = 3'd1;
            2'b01:   fb = 3'd2;
            2'b10:   fb = 3'd2;
            2'b11:   fb = 3'd4;
            default: fb = 3'd1;
        endcase
        return fb;
    endfunction

endpackage

// File: rtl/wav_pcm_streamer_if.sv
// Memory read bus plus the Audio_Controller write port of the streamer.
// master = streamer side, slave = memory / audio controller side.
interface wav_pcm_streamer_if #(parameter int ADDR_W = 20);

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              mem_rvalid;
    logic              audio_out_allowed;
    logic              write_audio_out;
    logic [15:0]       left_channel_audio_out;
    logic [15:0]       right_channel_audio_out;
    logic              clear_audio_out_memory;

    modport master (
        output mem_addr, mem_rd,
        input  mem_rdata, mem_rvalid,
        input  audio_out_allowed,
        output write_audio_out, left_channel_audio_out, right_channel_audio_out,
        output clear_audio_out_memory
    );

    modport slave (
        input  mem_addr, mem_rd,
        output mem_rdata, mem_rvalid,
        output audio_out_allowed,
        input  write_audio_out, left_channel_audio_out, right_channel_audio_out,
        input  clear_audio_out_memory
    );

endinterface

// File: rtl/wav_pcm_convert.sv
// Combinational PCM frame converter: little-endian frame bytes in, two
// signed 16-bit channels out, attenuated by an arithmetic right shift.
module wav_pcm_convert (
    input  logic [31:0] frame_i,
    input  logic        stereo_i,
    input  logic        bits16_i,
    input  logic [2:0]  vol_shift_i,
    output logic [15:0] left_o,
    output logic [15:0] right_o
);

    logic signed [15:0] s0_s;
    logic signed [15:0] s1_s;
    logic signed [15:0] l_s;
    logic signed [15:0] r_s;

    // Widen each raw sample to signed 16-bit and route mono/stereo to channels.
    always_comb begin
        s0_s = 16'sd0;
        s1_s = 16'sd0;
        if (bits16_i) begin
            s0_s = {frame_i[15:8], frame_i[7:0]};
            s1_s = {frame_i[31:24], frame_i[23:16]};
        end else begin
            // 8-bit WAV samples are unsigned; flipping the MSB recentres them.
            s0_s = {frame_i[7:0] ^ 8'h80, 8'h00};
            s1_s = {frame_i[15:8] ^ 8'h80, 8'h00};
        end
        l_s = s0_s;
        if (stereo_i) begin
            r_s = s1_s;
        end else begin
            r_s = s0_s;
        end
    end

    assign left_o  = l_s >>> vol_shift_i;
    assign right_o = r_s >>> vol_shift_i;

endmodule

// File: rtl/wav_pcm_streamer.sv
// WAV PCM streamer: fetches and validates a 44-byte WAV header from byte
// memory, then streams PCM frames to the Audio_Controller one frame per write.
module wav_pcm_streamer
    import wav_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [2:0]           vol_shift,
    wav_pcm_streamer_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [ADDR_W:0] DATA_ADDR = (ADDR_W+1)'(DATA_OFS);

    wav_state_e          state_q;
    // One extra bit flags that the address space has been exhausted.
    logic [ADDR_W:0]     addr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                rd_q;
    logic                pending_q;
    logic [5:0]          hdr_idx_q;
    logic [7:0]          hdr_q [HDR_BYTES];
    logic [31:0]         data_size_q;
    logic [31:0]         bytes_left_q;
    logic [2:0]          fb_q;
    logic                stereo_q;
    logic                bits16_q;
    logic [2:0]          byte_cnt_q;
    logic [3:0][7:0]     frame_q;
    logic                write_q;
    logic [15:0]         left_q;
    logic [15:0]         right_q;
    logic                clear_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;

    logic                rvalid_s;
    logic                active_s;
    logic [15:0]         fmt_s;
    logic [15:0]         ch_s;
    logic [15:0]         bps_s;
    logic [31:0]         data_size_s;
    logic                hdr_ok_s;
    logic [15:0]         conv_left_s;
    logic [15:0]         conv_right_s;

    assign rvalid_s = bus.mem_rvalid;

    // States in which stop aborts playback.
    assign active_s = (state_q == ST_HDR)   || (state_q == ST_CHECK) ||
                      (state_q == ST_FETCH) || (state_q == ST_WAIT)  ||
                      (state_q == ST_WRITE) || (state_q == ST_END);

    assign fmt_s       = {hdr_q[OFS_FMT+1], hdr_q[OFS_FMT]};
    assign ch_s        = {hdr_q[OFS_CHANNELS+1], hdr_q[OFS_CHANNELS]};
    assign bps_s       = {hdr_q[OFS_BPS+1], hdr_q[OFS_BPS]};
    assign data_size_s = {hdr_q[OFS_DATA_SIZE+3], hdr_q[OFS_DATA_SIZE+2],
                          hdr_q[OFS_DATA_SIZE+1], hdr_q[OFS_DATA_SIZE]};

    assign hdr_ok_s =
        ({hdr_q[OFS_RIFF], hdr_q[OFS_RIFF+1], hdr_q[OFS_RIFF+2], hdr_q[OFS_RIFF+3]} == ASCII_RIFF) &&
        ({hdr_q[OFS_WAVE], hdr_q[OFS_WAVE+1], hdr_q[OFS_WAVE+2], hdr_q[OFS_WAVE+3]} == ASCII_WAVE) &&
        ({hdr_q[OFS_DATA_ID], hdr_q[OFS_DATA_ID+1], hdr_q[OFS_DATA_ID+2], hdr_q[OFS_DATA_ID+3]} == ASCII_DATA) &&
        (fmt_s == 16'd1) &&
        ((ch_s == 16'd1) || (ch_s == 16'd2)) &&
        ((bps_s == 16'd8) || (bps_s == 16'd16));

    wav_pcm_convert u_convert (
        .frame_i     (frame_q),
        .stereo_i    (stereo_q),
        .bits16_i    (bits16_q),
        .vol_shift_i (vol_shift),
        .left_o      (conv_left_s),
        .right_o     (conv_right_s)
    );

    // Playback FSM: header fetch/check, frame gather, write handshake, stop/drain.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            mem_addr_q   <= '0;
            rd_q         <= 1'b0;
            pending_q    <= 1'b0;
            hdr_idx_q    <= 6'd0;
            for (int i = 0; i < HDR_BYTES; i++) begin
                hdr_q[i] <= 8'h00;
            end
            data_size_q  <= 32'd0;
            bytes_left_q <= 32'd0;
            fb_q         <= 3'd0;
            stereo_q     <= 1'b0;
            bits16_q     <= 1'b0;
            byte_cnt_q   <= 3'd0;
            frame_q      <= '0;
            write_q      <= 1'b0;
            left_q       <= 16'd0;
            right_q      <= 16'd0;
            clear_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            rd_q    <= 1'b0;
            write_q <= 1'b0;
            clear_q <= 1'b0;
            if (stop && active_s) begin
                // A read already in flight must still be absorbed before going idle.
                busy_q <= 1'b0;
                if (pending_q && !rvalid_s) begin
                    state_q <= ST_DRAIN;
                end else begin
                    pending_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (start && !stop) begin
                            state_q    <= ST_HDR;
                            clear_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            error_q    <= 1'b0;
                            addr_q     <= '0;
                            mem_addr_q <= '0;
                            hdr_idx_q  <= 6'd0;
                            byte_cnt_q <= 3'd0;
                            pending_q  <= 1'b0;
                        end
                    end
                    ST_HDR: begin
                        if (pending_q) begin
                            if (rvalid_s) begin
                                hdr_q[hdr_idx_q] <= bus.mem_rdata;
                                hdr_idx_q        <= hdr_idx_q + 6'd1;
                                pending_q        <= 1'b0;
                                if (hdr_idx_q == 6'(HDR_BYTES - 1)) begin
                                    state_q <= ST_CHECK;
                                end
                            end
                        end else begin
                            rd_q       <= 1'b1;
                            pending_q  <= 1'b1;
                            mem_addr_q <= addr_q[ADDR_W-1:0];
                            addr_q     <= addr_q + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        if (hdr_ok_s) begin
                            data_size_q  <= data_size_s;
                            bytes_left_q <= data_size_s;
                            stereo_q     <= (ch_s == 16'd2);
                            bits16_q     <= (bps_s == 16'd16);
                            fb_q         <= frame_bytes(ch_s == 16'd2, bps_s == 16'd16);
                            addr_q       <= DATA_ADDR;
                            byte_cnt_q   <= 3'd0;
                            state_q      <= ST_FETCH;
                        end else begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_ERROR;
                        end
                    end
                    ST_FETCH: begin
                        if (pending_q) begin
                            if (rvalid_s) begin
                                frame_q[byte_cnt_q[1:0]] <= bus.mem_rdata;
                                pending_q                <= 1'b0;
                                if ((byte_cnt_q + 3'd1) == fb_q) begin
                                    byte_cnt_q <= 3'd0;
                                    state_q    <= ST_WAIT;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + 3'd1;
                                end
                            end
                        end else if ((byte_cnt_q == 3'd0) && (bytes_left_q < {29'd0, fb_q})) begin
                            // Fewer bytes than a whole frame remain: the tail is dropped.
                            state_q <= ST_END;
                        end else if (addr_q[ADDR_W]) begin
                            state_q <= ST_END;
                        end else begin
                            rd_q       <= 1'b1;
                            pending_q  <= 1'b1;
                            mem_addr_q <= addr_q[ADDR_W-1:0];
                            addr_q     <= addr_q + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.audio_out_allowed) begin
                            write_q <= 1'b1;
                            left_q  <= conv_left_s;
                            right_q <= conv_right_s;
                            state_q <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        bytes_left_q <= bytes_left_q - {29'd0, fb_q};
                        state_q      <= ST_FETCH;
                    end
                    ST_END: begin
                        if (loop_en) begin
                            bytes_left_q <= data_size_q;
                            addr_q       <= DATA_ADDR;
                            byte_cnt_q   <= 3'd0;
                            state_q      <= ST_FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DRAIN: begin
                        if (rvalid_s) begin
                            pending_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.mem_addr                = mem_addr_q;
    assign bus.mem_rd                  = rd_q;
    assign bus.write_audio_out         = write_q;
    assign bus.left_channel_audio_out  = left_q;
    assign bus.right_channel_audio_out = right_q;
    assign bus.clear_audio_out_memory  = clear_q;
    assign busy                        = busy_q;
    assign done                        = done_q;
    assign error                       = error_q;

endmodule

// File: tb/tb_wav_pcm_streamer.sv
// Self-checking bench for wav_pcm_streamer: directed scenarios plus randomized
// WAV images compared against a header-parsing reference model.
module tb_wav_pcm_streamer;

    localparam int ADDR_W = 20;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       loop_en  = 1'b0;
    logic [2:0] vol_shift = 3'd0;
    logic       busy;
    logic       done;
    logic       error;

    wav_pcm_streamer_if #(.ADDR_W(ADDR_W)) bus ();

    wav_pcm_streamer #(.ADDR_W(ADDR_W)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .vol_shift (vol_shift),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte memory with one outstanding read and programmable latency.
    logic [7:0]        wav_mem [0:1023];
    int                mem_delay = 1;
    int                lat_q;
    logic [ADDR_W-1:0] ra_q;
    bit                pend_q;
    int                ovl = 0;

    always @(posedge CLOCK_50) begin
        bus.mem_rvalid <= 1'b0;
        if (reset) begin
            pend_q <= 1'b0;
        end else begin
            if (pend_q) begin
                if (lat_q <= 1) begin
                    bus.mem_rvalid <= 1'b1;
                    bus.mem_rdata  <= wav_mem[ra_q[9:0]];
                    pend_q         <= 1'b0;
                end else begin
                    lat_q <= lat_q - 1;
                end
            end
            if (bus.mem_rd) begin
                if (pend_q) ovl <= ovl + 1;
                pend_q <= 1'b1;
                lat_q  <= mem_delay;
                ra_q   <= bus.mem_addr;
            end
        end
    end

    // Monitors: frame writes and read addresses.
    logic [15:0]       got_l[$];
    logic [15:0]       got_r[$];
    logic [ADDR_W-1:0] rd_log[$];

    always @(negedge CLOCK_50) begin
        if (!reset && bus.write_audio_out) begin
            got_l.push_back(bus.left_channel_audio_out);
            got_r.push_back(bus.right_channel_audio_out);
        end
        if (!reset && bus.mem_rd) rd_log.push_back(bus.mem_addr);
    end

    // Reference model.
    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];
    bit          exp_ok;

    function automatic int le(input int a, input int n);
        int v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + int'(wav_mem[a + i]);
        return v;
    endfunction

    function automatic logic [15:0] smp(input int a, input int bps, input int vol);
        int v;
        if (bps == 16) begin
            v = le(a, 2);
            if (v >= 32768) v = v - 65536;
        end else begin
            v = (int'(wav_mem[a]) - 128) * 256;
        end
        v = v >>> vol;
        return v[15:0];
    endfunction

    task automatic model(input int vol);
        int ch, bps, fb, nf, base;
        exp_l.delete();
        exp_r.delete();
        ch  = le(22, 2);
        bps = le(34, 2);
        exp_ok = ({wav_mem[0], wav_mem[1], wav_mem[2], wav_mem[3]} == "RIFF") &&
                 ({wav_mem[8], wav_mem[9], wav_mem[10], wav_mem[11]} == "WAVE") &&
                 ({wav_mem[36], wav_mem[37], wav_mem[38], wav_mem[39]} == "data") &&
                 (le(20, 2) == 1) && (ch == 1 || ch == 2) && (bps == 8 || bps == 16);
        if (exp_ok) begin
            fb = ch * bps / 8;
            nf = le(40, 4) / fb;
            for (int f = 0; f < nf; f++) begin
                base = 44 + f * fb;
                exp_l.push_back(smp(base, bps, vol));
                exp_r.push_back(smp((ch == 2) ? base + bps / 8 : base, bps, vol));
            end
        end
    endtask

    task automatic put(input int a, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) wav_mem[a + i] = v[8*i +: 8];
    endtask

    task automatic put_tag(input int a, input logic [31:0] t);
        for (int i = 0; i < 4; i++) wav_mem[a + i] = t[31 - 8*i -: 8];
    endtask

    task automatic build_wav(input int ch, input int bps, input int ds);
        put_tag(0, "RIFF");  put(4, 4, 36 + ds);  put_tag(8, "WAVE");
        put_tag(12, "fmt "); put(16, 4, 16);      put(20, 2, 1);
        put(22, 2, ch);      put(24, 4, 8000);    put(28, 4, 8000 * ch * bps / 8);
        put(32, 2, ch * bps / 8); put(34, 2, bps);
        put_tag(36, "data"); put(40, 4, ds);
    endtask

    task automatic start_run();
        got_l.delete();
        got_r.delete();
        rd_log.delete();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget, input bit rnd);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge CLOCK_50);
            n++;
            if (rnd) bus.audio_out_allowed = 1'($urandom_range(0, 1));
        end
        bus.audio_out_allowed = 1'b1;
        chk({tag, "_finished"}, {31'd0, done | error}, 32'd1);
    endtask

    task automatic wait_reads(input string tag, input int n);
        int c = 0;
        while (rd_log.size() < n && c < 2000) begin
            @(negedge CLOCK_50);
            c++;
        end
        chk({tag, "_reads_reached"}, {31'd0, rd_log.size() >= n}, 32'd1);
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_nwrites"}, got_l.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
            chk($sformatf("%s_L%0d", tag, i), got_l[i], exp_l[i]);
            chk($sformatf("%s_R%0d", tag, i), got_r[i], exp_r[i]);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_mem_rd"}, {31'd0, bus.mem_rd}, 32'd0);
        chk({p, "_mem_addr"}, {12'd0, bus.mem_addr}, 32'd0);
        chk({p, "_write"}, {31'd0, bus.write_audio_out}, 32'd0);
        chk({p, "_left"}, {16'd0, bus.left_channel_audio_out}, 32'd0);
        chk({p, "_right"}, {16'd0, bus.right_channel_audio_out}, 32'd0);
        chk({p, "_clear"}, {31'd0, bus.clear_audio_out_memory}, 32'd0);
        chk({p, "_busy"}, {31'd0, busy}, 32'd0);
        chk({p, "_done"}, {31'd0, done}, 32'd0);
        chk({p, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        int n, nw, nr, bad;
        logic [15:0] snap_l, snap_r;

        bus.audio_out_allowed = 1'b1;
        for (int i = 0; i < 1024; i++) wav_mem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        chk_zero("rst");
        reset = 1'b0;
        @(negedge CLOCK_50);

        // 16-bit stereo, two frames
        build_wav(2, 16, 8);
        put(44, 2, 16'h1234); put(46, 2, 16'hFEDC); put(48, 2, 16'h8000); put(50, 2, 16'h7FFF);
        model(0);
        got_l.delete(); got_r.delete(); rd_log.delete();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        chk("t1_clear", {31'd0, bus.clear_audio_out_memory}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_end("t1", 2000, 1'b0);
        cmp_writes("t1");
        chk("t1_L0_direct", got_l.size() > 0 ? got_l[0] : 16'hDEAD, 16'h1234);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);

        // 8-bit mono: 0x00, 0x80, 0xFF
        build_wav(1, 8, 3);
        wav_mem[44] = 8'h00; wav_mem[45] = 8'h80; wav_mem[46] = 8'hFF;
        model(0);
        start_run();
        wait_end("t2", 2000, 1'b0);
        cmp_writes("t2");
        chk("t2_last", got_l.size() == 3 ? got_l[2] : 16'hDEAD, 16'h7F00);
        chk("t2_done", {31'd0, done}, 32'd1);

        // Bad header: RIFX, then 24-bit samples
        build_wav(2, 16, 8);
        wav_mem[3] = 8'h58;
        start_run();
        wait_end("t3a", 2000, 1'b0);
        chk("t3a_error", {31'd0, error}, 32'd1);
        chk("t3a_busy", {31'd0, busy}, 32'd0);
        chk("t3a_nwrites", got_l.size(), 0);
        chk("t3a_hdr_reads", rd_log.size(), 44);
        repeat (20) @(negedge CLOCK_50);
        chk("t3a_rd_idle", rd_log.size(), 44);
        build_wav(2, 24, 12);
        start_run();
        wait_end("t3b", 2000, 1'b0);
        chk("t3b_error", {31'd0, error}, 32'd1);
        chk("t3b_done", {31'd0, done}, 32'd0);
        chk("t3b_nwrites", got_l.size(), 0);

        // allowed held low after the first frame is gathered
        build_wav(2, 16, 8);
        put(44, 2, 16'h1234); put(46, 2, 16'hFEDC); put(48, 2, 16'h8000); put(50, 2, 16'h7FFF);
        model(0);
        bus.audio_out_allowed = 1'b0;
        start_run();
        wait_reads("t4", 48);
        repeat (5) @(negedge CLOCK_50);
        snap_l = bus.left_channel_audio_out;
        snap_r = bus.right_channel_audio_out;
        bad = 0;
        repeat (100) begin
            @(negedge CLOCK_50);
            if (bus.write_audio_out || bus.left_channel_audio_out != snap_l ||
                bus.right_channel_audio_out != snap_r) bad++;
        end
        chk("t4_hold_stable", bad, 0);
        chk("t4_no_write", got_l.size(), 0);
        bus.audio_out_allowed = 1'b1;
        @(negedge CLOCK_50);
        chk("t4_write_next", {31'd0, bus.write_audio_out}, 32'd1);
        chk("t4_L", {16'd0, bus.left_channel_audio_out}, 32'h1234);
        chk("t4_R", {16'd0, bus.right_channel_audio_out}, 32'hFEDC);
        wait_end("t4", 2000, 1'b0);
        cmp_writes("t4");

        // Looping two-frame file, then stop with a slow read outstanding
        build_wav(1, 16, 4);
        put(44, 2, 16'h1111); put(46, 2, 16'h2222);
        loop_en = 1'b1;
        start_run();
        n = 0;
        while (got_l.size() < 4 && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("t5_four_writes", {31'd0, got_l.size() >= 4}, 32'd1);
        for (int i = 0; i < 4 && i < got_l.size(); i++) begin
            chk($sformatf("t5_loop_L%0d", i), got_l[i], (i % 2 == 0) ? 16'h1111 : 16'h2222);
            chk($sformatf("t5_loop_R%0d", i), got_r[i], (i % 2 == 0) ? 16'h1111 : 16'h2222);
        end
        chk("t5_readdr_44", rd_log.size() > 48 ? {12'd0, rd_log[48]} : 32'hDEAD, 32'd44);
        mem_delay = 5;
        n = 0;
        @(negedge CLOCK_50);
        while (!bus.mem_rd && n < 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("t5_rd_seen", {31'd0, bus.mem_rd}, 32'd1);
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
        chk("t5_stop_busy", {31'd0, busy}, 32'd0);
        nw = got_l.size();
        nr = rd_log.size();
        repeat (20) @(negedge CLOCK_50);
        chk("t5_no_write_after_stop", got_l.size(), nw);
        chk("t5_no_read_after_stop", rd_log.size(), nr);
        chk("t5_idle_done", {31'd0, done}, 32'd0);
        loop_en = 1'b0;
        mem_delay = 1;

        // Attenuation and a discarded odd byte
        build_wav(1, 16, 5);
        put(44, 2, 16'h8000); put(46, 2, 16'h1234); wav_mem[48] = 8'h55;
        vol_shift = 3'd2;
        model(2);
        start_run();
        wait_end("t6", 2000, 1'b0);
        cmp_writes("t6");
        chk("t6_first", got_l.size() > 0 ? got_l[0] : 16'hDEAD, 16'hE000);
        chk("t6_second", got_l.size() > 1 ? got_l[1] : 16'hDEAD, 16'h048D);
        chk("t6_done", {31'd0, done}, 32'd1);
        vol_shift = 3'd0;

        // Reset while fetching data
        build_wav(2, 16, 8);
        start_run();
        wait_reads("t6r", 46);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk_zero("t6r");
        reset = 1'b0;
        @(negedge CLOCK_50);

        // Randomized images against the reference model
        for (int it = 0; it < 12; it++) begin
            int ch, bps, ds, vol;
            ch  = $urandom_range(1, 2);
            bps = ($urandom_range(0, 1) == 1) ? 16 : 8;
            ds  = $urandom_range(0, 20);
            vol = $urandom_range(0, 7);
            build_wav(ch, bps, ds);
            for (int i = 0; i < ds; i++) wav_mem[44 + i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0:       wav_mem[9] = 8'h58;
                    1:       put(20, 2, 3);
                    2:       put(22, 2, 3);
                    3:       put(34, 2, 12);
                    default: wav_mem[38] = 8'h00;
                endcase
            end
            vol_shift = 3'(vol);
            mem_delay = $urandom_range(1, 4);
            model(vol);
            start_run();
            wait_end($sformatf("rnd%0d", it), 4000, 1'b1);
            cmp_writes($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d_done", it), {31'd0, done}, {31'd0, exp_ok});
            chk($sformatf("rnd%0d_error", it), {31'd0, error}, {31'd0, !exp_ok});
        end

        chk("read_overlap", ovl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
